// File: rtl/spi_fifo.sv
// spi_fifo: buffered byte-stream front end for the SPI byte engine.
//
// The CPU pushes TX bytes and pops RX bytes through two word registers on the
// 68k bus. Queued TX bytes are handed to the engine one at a time. The byte the
// engine receives for each one is stored in the RX FIFO.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   data_write[15:0]     bus write data
//   data_read[15:0]      bus read data (registered)
//   addr[7:0]            register byte address (addr[7:1] = 0 ctl/data, 1 counts)
//   uds, lds, rw         upper/lower data strobes, 1 = read
//   ack                  one-cycle access acknowledge
//   xfer_start           one-cycle pulse, the engine starts a byte
//   xfer_tx[7:0]         byte to send, held from start until done
//   xfer_busy            engine active flag
//   xfer_rx[7:0]         received byte, valid once xfer_busy falls
//   irq                  level interrupt request (registered)
module spi_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  input  logic [7:0]  addr,
  input  logic        uds,
  input  logic        lds,
  input  logic        rw,
  output logic        ack,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx,
  input  logic        xfer_busy,
  input  logic [7:0]  xfer_rx,
  output logic        irq
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone, StStore} state_e;

  state_e      state_q;
  logic [7:0]  tx_mem [Depth];
  logic [7:0]  rx_mem [Depth];
  ptr_t        tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
  cnt_t        tx_count_q, rx_count_q;
  logic        overrun_q, run_q, rx_store_q, tx_irq_en_q, rx_irq_en_q;
  logic        discard_q;
  logic        strobe_q;
  logic [15:0] data_read_q;
  logic        ack_q, irq_q, xfer_start_q;
  logic [7:0]  xfer_tx_q;

  // Bus decode; only the first cycle of a strobe assertion has side effects.
  logic strobe, strobe_edge, sel_ctl, sel_cnt, acc;
  logic wr_tx, wr_ctl, rd_rx, flush, clr_ovr;
  logic tx_empty, tx_full, rx_empty, rx_full, busy;
  logic tx_pop, tx_push, tx_drop, rx_pop, rx_push, rx_drop, store_req;
  logic [7:0] status;

  assign strobe      = uds | lds;
  assign strobe_edge = strobe & ~strobe_q;
  assign sel_ctl     = (addr[7:1] == 7'd0);
  assign sel_cnt     = (addr[7:1] == 7'd1);
  assign acc         = strobe_edge & (sel_ctl | sel_cnt);
  assign wr_tx       = acc & sel_ctl & ~rw & uds;
  assign wr_ctl      = acc & sel_ctl & ~rw & lds;
  assign rd_rx       = acc & sel_ctl & rw & uds;
  assign flush       = wr_ctl & data_write[7];
  assign clr_ovr     = wr_ctl & data_write[6];

  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = tx_count_q[DEPTH_LOG2];
  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = rx_count_q[DEPTH_LOG2];
  assign busy     = (state_q != StIdle) | ~tx_empty;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign tx_pop    = (state_q == StIdle) & run_q & ~tx_empty;
  assign tx_push   = wr_tx & (~tx_full | tx_pop);
  assign tx_drop   = wr_tx & ~tx_push;
  assign rx_pop    = rd_rx & ~rx_empty;
  assign store_req = (state_q == StStore) & rx_store_q & ~discard_q & ~flush;
  assign rx_push   = store_req & (~rx_full | rx_pop);
  assign rx_drop   = store_req & ~rx_push;

  assign status = {tx_full, tx_empty, rx_full, rx_empty, overrun_q,
                   tx_irq_en_q, rx_irq_en_q, busy};

  logic unused_bits;
  assign unused_bits = ^{data_write[5:4], addr[0]};

  // Storage arrays need no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= data_write[15:8];
    if (rx_push) rx_mem[rx_wr_ptr_q] <= xfer_rx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      overrun_q   <= 1'b0;
      run_q       <= 1'b1;
      rx_store_q  <= 1'b1;
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      discard_q   <= 1'b0;
      strobe_q    <= 1'b0;
      data_read_q <= '0;
      ack_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      strobe_q <= strobe;
      ack_q    <= acc;

      if (flush) begin
        tx_wr_ptr_q <= '0;
        tx_rd_ptr_q <= '0;
        rx_wr_ptr_q <= '0;
        rx_rd_ptr_q <= '0;
        tx_count_q  <= '0;
        rx_count_q  <= '0;
      end else begin
        if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
        if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
        if (tx_push && !tx_pop)      tx_count_q <= tx_count_q + 1'b1;
        else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - 1'b1;
        if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
        if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
        if (rx_push && !rx_pop)      rx_count_q <= rx_count_q + 1'b1;
        else if (!rx_push && rx_pop) rx_count_q <= rx_count_q - 1'b1;
      end

      // A drop in the same cycle as a clear request wins so no loss goes unseen.
      if (tx_drop || rx_drop) overrun_q <= 1'b1;
      else if (clr_ovr)       overrun_q <= 1'b0;

      if (wr_ctl) begin
        tx_irq_en_q <= data_write[3];
        rx_irq_en_q <= data_write[2];
        rx_store_q  <= data_write[1];
        run_q       <= data_write[0];
      end

      // Flushing while a byte is with the engine: drop its reply at STORE.
      if (state_q == StStore) discard_q <= 1'b0;
      else if (flush && (state_q != StIdle || tx_pop)) discard_q <= 1'b1;

      if (acc && rw) begin
        if (sel_ctl) begin
          if (uds) data_read_q[15:8] <= rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
          if (lds) data_read_q[7:0]  <= status;
        end else begin
          if (uds) data_read_q[15:8] <= 8'(rx_count_q);
          if (lds) data_read_q[7:0]  <= 8'(tx_count_q);
        end
      end

      irq_q <= (rx_irq_en_q & ~rx_empty) | (tx_irq_en_q & tx_empty & (state_q == StIdle));
    end
  end

  // Dispatch FSM: one byte in flight at a time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      xfer_start_q <= 1'b0;
      xfer_tx_q    <= '0;
    end else begin
      xfer_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_pop) begin
            xfer_start_q <= 1'b1;
            xfer_tx_q    <= tx_mem[tx_rd_ptr_q];
            state_q      <= StWaitBusy;
          end
        end
        StWaitBusy: if (xfer_busy)  state_q <= StWaitDone;
        StWaitDone: if (!xfer_busy) state_q <= StStore;
        StStore:    state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign data_read  = data_read_q;
  assign ack        = ack_q;
  assign irq        = irq_q;
  assign xfer_start = xfer_start_q;
  assign xfer_tx    = xfer_tx_q;

endmodule

// File: tb/tb_spi_fifo.sv
module tb_spi_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_write = '0;
  logic [15:0] data_read;
  logic [7:0]  addr = '0;
  logic        uds = 1'b0;
  logic        lds = 1'b0;
  logic        rw = 1'b1;
  logic        ack;
  logic        xfer_start;
  logic [7:0]  xfer_tx;
  logic        xfer_busy = 1'b0;
  logic [7:0]  xfer_rx = '0;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  logic eng_active = 1'b0;
  logic [7:0] sent [$];

  spi_fifo #(.DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_write (data_write),
    .data_read  (data_read),
    .addr       (addr),
    .uds        (uds),
    .lds        (lds),
    .rw         (rw),
    .ack        (ack),
    .xfer_start (xfer_start),
    .xfer_tx    (xfer_tx),
    .xfer_busy  (xfer_busy),
    .xfer_rx    (xfer_rx),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Engine model: echoes the inverted byte after a 3-cycle active period.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (xfer_start === 1'b1) begin
        eng_active = 1'b1;
        b = xfer_tx;
        sent.push_back(b);
        start_cnt++;
        @(negedge clk);
        xfer_busy = 1'b1;
        xfer_rx   = ~b;
        repeat (3) @(negedge clk);
        xfer_busy  = 1'b0;
        eng_active = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic r, input logic u, input logic l, input logic [7:0] a,
                     input logic [15:0] wd, output logic [15:0] rd);
    logic got_ack;
    @(negedge clk);
    rw = r; uds = u; lds = l; addr = a; data_write = wd;
    @(negedge clk);
    got_ack = ack;
    rd = data_read;
    uds = 1'b0; lds = 1'b0; rw = 1'b1;
    @(negedge clk);
    check("ack", {15'd0, got_ack}, 16'd1);
  endtask

  task automatic push(input logic [7:0] b);
    logic [15:0] d;
    bus(1'b0, 1'b1, 1'b0, 8'h00, {b, 8'h00}, d);
  endtask

  task automatic ctl(input logic [7:0] c);
    logic [15:0] d;
    bus(1'b0, 1'b0, 1'b1, 8'h00, {8'h00, c}, d);
  endtask

  task automatic rd_rx(output logic [7:0] v);
    logic [15:0] d;
    bus(1'b1, 1'b1, 1'b0, 8'h00, 16'h0, d);
    v = d[15:8];
  endtask

  task automatic rd_status(output logic [7:0] v);
    logic [15:0] d;
    bus(1'b1, 1'b0, 1'b1, 8'h00, 16'h0, d);
    v = d[7:0];
  endtask

  task automatic rd_counts(output logic [7:0] rxc, output logic [7:0] txc);
    logic [15:0] d;
    bus(1'b1, 1'b1, 1'b1, 8'h02, 16'h0, d);
    rxc = d[15:8];
    txc = d[7:0];
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (start_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    assert (start_cnt >= n) else begin
      errors++;
      $error("FAIL start_wait: got %0d starts expected %0d", start_cnt, n);
    end
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    wait_starts(n);
    while (eng_active && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v, rxc, txc;
    int acks;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data_read", data_read, 16'h0000);
    check("rst_ack", {15'd0, ack}, 16'd0);
    check("rst_start", {15'd0, xfer_start}, 16'd0);
    check("rst_xfer_tx", {8'd0, xfer_tx}, 16'd0);
    check("rst_irq", {15'd0, irq}, 16'd0);
    reset_n = 1'b1;
    rd_status(v);
    check("rst_status", {8'd0, v}, 16'h0050);

    // Single byte echo.
    push(8'hA5);
    wait_done(1);
    check("echo_starts", 16'(start_cnt), 16'd1);
    check("echo_tx", {8'd0, sent[0]}, 16'h00A5);
    rd_rx(v);
    check("echo_rx", {8'd0, v}, 16'h005A);
    rd_status(v);
    check("echo_status", {8'd0, v}, 16'h0050);

    // Fill TX with run=0, 17th byte overflows.
    ctl(8'h02);
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hFF);
    rd_counts(rxc, txc);
    check("txfull_count", {8'd0, txc}, 16'h0010);
    rd_status(v);
    check("txfull_status", {8'd0, v}, 16'h0099);
    ctl(8'h43);
    wait_done(17);
    repeat (20) @(negedge clk);
    check("txfull_starts", 16'(start_cnt), 16'd17);
    for (int i = 0; i < 16; i++) check("txfull_order", {8'd0, sent[i+1]}, 16'(i));

    // RX now full from the echoes; one more byte overruns.
    rd_counts(rxc, txc);
    check("rxfull_count", {8'd0, rxc}, 16'h0010);
    push(8'h77);
    wait_done(18);
    rd_counts(rxc, txc);
    check("rxovr_count", {8'd0, rxc}, 16'h0010);
    rd_status(v);
    check("rxovr_status", {8'd0, v}, 16'h0068);
    for (int i = 0; i < 16; i++) begin
      rd_rx(v);
      check("rxovr_data", {8'd0, v}, {8'd0, 8'hFF - 8'(i)});
    end
    ctl(8'h43);
    rd_status(v);
    check("ovr_clear_status", {8'd0, v}, 16'h0050);

    // Held read strobe: one ack, one pop.
    push(8'hEE);
    push(8'hDD);
    wait_done(20);
    @(negedge clk);
    rw = 1'b1; uds = 1'b1; addr = 8'h00;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    v = data_read[15:8];
    uds = 1'b0;
    @(negedge clk);
    check("hold_acks", 16'(acks), 16'd1);
    check("hold_data", {8'd0, v}, 16'h0011);
    rd_counts(rxc, txc);
    check("hold_rx_count", {8'd0, rxc}, 16'h0001);
    rd_rx(v);
    check("hold_second", {8'd0, v}, 16'h0022);

    // Flush while byte 2 of 4 is in flight.
    ctl(8'h02);
    for (int i = 1; i <= 4; i++) push(8'h30 + 8'(i));
    ctl(8'h03);
    wait_starts(22);
    ctl(8'h83);
    wait_done(22);
    repeat (20) @(negedge clk);
    check("flush_starts", 16'(start_cnt), 16'd22);
    check("flush_byte2", {8'd0, sent[21]}, 16'h0032);
    rd_counts(rxc, txc);
    check("flush_rx_count", {8'd0, rxc}, 16'h0000);
    rd_status(v);
    check("flush_status", {8'd0, v}, 16'h0050);

    // Interrupt and reset mid-byte.
    ctl(8'h07);
    repeat (2) @(negedge clk);
    check("irq_empty", {15'd0, irq}, 16'd0);
    push(8'h42);
    wait_done(23);
    check("irq_set", {15'd0, irq}, 16'd1);
    rd_rx(v);
    check("irq_data", {8'd0, v}, 16'h00BD);
    repeat (2) @(negedge clk);
    check("irq_clear", {15'd0, irq}, 16'd0);
    push(8'h10);
    wait_starts(24);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_data_read", data_read, 16'h0000);
    check("mid_rst_ack", {15'd0, ack}, 16'd0);
    check("mid_rst_start", {15'd0, xfer_start}, 16'd0);
    check("mid_rst_xfer_tx", {8'd0, xfer_tx}, 16'd0);
    check("mid_rst_irq", {15'd0, irq}, 16'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
